// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, arbiter FSM states, the tag prefix
// and the baud-divisor helper.
package uart_pkg;

  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;
  localparam int         DATA_BITS = 8;
  localparam logic [7:0] TAG_BASE  = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } arb_state_e;

  // Nearest-integer clocks per bit.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each held BAUD_DIV clocks. ready is low for the whole frame.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd
);

  localparam int CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int FRAME_BITS = DATA_BITS + 2;

  logic                 active;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS:0]   shreg;
  logic                 bit_end;
  logic                 frame_end;
  logic                 accept;

  assign ready     = !active;
  assign accept    = !active && valid;
  assign bit_end   = active && (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign frame_end = bit_end && (bit_cnt == 4'(FRAME_BITS - 1));

  // txd is a flop with async set so a reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      txd      <= STOP_BIT;
    end else if (accept) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      txd      <= START_BIT;
    end else if (frame_end) begin
      active   <= 1'b0;
      baud_cnt <= '0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
      txd      <= shreg[0];
    end else if (active) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Payload plus stop bit; shifted out one position per bit period.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {STOP_BIT, data};
    end else if (bit_end && !frame_end) begin
      shreg <= {1'b0, shreg[DATA_BITS:1]};
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// streams, packet-atomic with idle-timeout revocation. Optional source tag
// frame per grant when UART_ARB_SRC_TAG_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*8-1:0]                     req_data,
  input  logic [NUM_REQ-1:0]                       req_last,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic                                     txd,
  output logic                                     busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_CYC   = IDLE_TIMEOUT * BAUD_DIV;
  localparam int TO_W     = $clog2(TO_CYC + 1);

  arb_state_e       state, state_nxt;
  logic [GID_W-1:0] grant_nxt;
  logic [GID_W-1:0] last_grant, last_nxt;
  logic [GID_W-1:0] rr_sel, rr_cand;
  logic             rr_found;
  logic [TO_W-1:0]  to_cnt, to_nxt;

  logic [7:0]       req_bytes [NUM_REQ];
  logic             holder_valid;
  logic             holder_acc;
  logic             tag_hold;
  logic             core_valid;
  logic             core_ready;
  logic [7:0]       core_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  assign holder_valid = req_valid[grant_id];
  assign holder_acc   = (state == GRANT) && !tag_hold && holder_valid && core_ready;
  assign busy         = (state != IDLE) || !core_ready;

  // Scan from last_grant+1 upward with wrap; the nearest candidate wins.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = GID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT && !tag_hold) begin
      req_ready[grant_id] = core_ready;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    to_nxt    = to_cnt;
    case (state)
      IDLE: begin
        to_nxt = '0;
        if (rr_found && core_ready) begin
          grant_nxt = rr_sel;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (holder_acc) begin
          to_nxt = '0;
          if (req_last[grant_id]) begin
            state_nxt = DRAIN;
            last_nxt  = grant_id;
          end
        end else if (holder_valid || tag_hold) begin
          to_nxt = '0;
        end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
          // Silent holder: revoke and demote it in the rotation.
          to_nxt    = '0;
          state_nxt = DRAIN;
          last_nxt  = grant_id;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (core_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GID_W'(NUM_REQ - 1);
      to_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      to_cnt     <= to_nxt;
    end
  end

`ifdef UART_ARB_SRC_TAG_EN
  logic tag_pend;

  // Set on every new grant; cleared when the core takes the tag byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pend <= 1'b0;
    end else if (state == IDLE && state_nxt == GRANT) begin
      tag_pend <= 1'b1;
    end else if (tag_pend && core_ready) begin
      tag_pend <= 1'b0;
    end
  end

  assign tag_hold   = tag_pend;
  assign core_valid = tag_pend ? (state == GRANT) : ((state == GRANT) && holder_valid);
  assign core_data  = tag_pend ? (TAG_BASE | 8'(grant_id)) : req_bytes[grant_id];
`else
  assign tag_hold   = 1'b0;
  assign core_valid = (state == GRANT) && holder_valid;
  assign core_data  = req_bytes[grant_id];
`endif

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .data  (core_data),
    .valid (core_valid),
    .ready (core_ready),
    .txd   (txd)
  );

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter CLK_FREQ, default 100000000: clk frequency in Hz.
REQ-003 SHALL have parameter BAUD, default 115200: line rate; BAUD_DIV = round(CLK_FREQ/BAUD), 868 at defaults.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 32: bit-times without valid from the holder before the grant is revoked mid-packet.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 SHALL have port req_data  input  NUM_REQ*8  per-requester byte; requester i on bits [8i+7:8i].
REQ-009 SHALL have port req_last  input  NUM_REQ  marks the final byte of a packet.
REQ-010 SHALL have port req_ready  output  NUM_REQ  byte accepted when valid and ready are both high.
REQ-011 SHALL have port txd  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a grant is held or a frame is in flight.
REQ-013 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the current or most recent holder.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, DRAIN.
REQ-015 IDLE: when any req_valid is high, SHALL select the first valid index searching round-robin from last_grant+1 (wrapping), latch it into grant_id and enter GRANT on the next cycle.
REQ-016 GRANT: req_ready[grant_id] SHALL equal core_ready; all other req_ready bits SHALL be 0 in every state.
REQ-017 Accepting a byte with req_last=1 SHALL move to DRAIN; last_grant SHALL update to grant_id at that point.
REQ-018 DRAIN: SHALL wait for core_ready, then enter IDLE; arbitration SHALL never start while a frame is in flight.
REQ-019 In GRANT, if req_valid[grant_id] stays low for IDLE_TIMEOUT*BAUD_DIV consecutive cycles, SHALL revoke the grant and enter DRAIN; last_grant SHALL update to grant_id so that requester loses priority.
REQ-020 Valid bits from non-holders SHALL be ignored until IDLE; simultaneous requests SHALL be resolved only by the round-robin rule.
REQ-021 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit lasting exactly BAUD_DIV cycles, 10*BAUD_DIV cycles per frame.
REQ-022 The start bit SHALL appear on txd on the cycle after acceptance; core_ready SHALL be low from acceptance until the frame completes, giving a back-to-back byte period of 10*BAUD_DIV+1 cycles.
REQ-023 A requester deasserting valid or changing data while ready is low SHALL have no effect.
REQ-024 busy SHALL be high in GRANT and DRAIN, and in IDLE while core_ready is low.

Reset
REQ-025 On rst, SHALL go to IDLE, with txd=1, req_ready=0, busy=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), and the baud and timeout counters cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with txd high asynchronously.

Configuration
REQ-027 With macro UART_ARB_SRC_TAG_EN defined, SHALL transmit a tag byte 0xF0|grant_id as the first frame after each IDLE->GRANT transition; req_ready SHALL be held low until the tag frame completes.
REQ-028 Without UART_ARB_SRC_TAG_EN, no tag SHALL be sent and no tag logic SHALL be synthesized.

Structure
REQ-029 Shared package uart_pkg SHALL hold the frame constants (START_BIT, STOP_BIT, DATA_BITS=8), the FSM state typedef, the TAG_BASE=0xF0 constant and the baud-divisor function.
REQ-030 The serializer SHALL be sub-module uart_tx_core (ports: clk, rst, data, valid, ready, txd); arbitration and the FSM SHALL live in the top module.

Verification (BAUD_DIV overridden to 4 in the bench)
REQ-031 Single byte 0x55 from requester 2 -> grant_id=2; txd sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, starting 1 cycle after accept.
REQ-032 Requesters 0 and 1 both send 3-byte packets simultaneously -> requester 0 is served fully with no interleaving, then requester 1; the next contention is won by 0 again only after 1 has been served.
REQ-033 Requester 3 holds the grant then idles for 32*4=128 cycles -> grant revoked at cycle 128, and a pending requester 1 is granted after the line drains.
REQ-034 Two back-to-back bytes -> second start bit begins exactly 41 cycles after the first start bit.
REQ-035 Assert rst at bit 5 of a frame -> txd=1 the same cycle; after release req_ready=0 until a new valid, and requester 0 wins the first arbitration.
REQ-036 With UART_ARB_SRC_TAG_EN and requester 1 sending 0xA5 -> frames 0xF1 then 0xA5 on the line; req_ready[1] low during the tag frame.
